// File: rtl/ctrl_pc_unit.sv
// ctrl_pc_unit: control and sequencing core of the 8-bit single-cycle processor.
//   - Decodes opcode (instr[7:4]) into datapath control signals (combinational).
//   - Holds the program counter and computes the next PC.
//   - Gates the branch condition (branch_taken = zero & Branch).
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset (clears pc)
//   opcode [3:0]   instruction bits [7:4]
//   zero           ALU zero flag
//   imm   [AW-1:0] extended immediate
//   sbeq  [AW-1:0] branch offset register value
//   pc    [AW-1:0] current PC / instruction memory address
//   branch_taken   zero & Branch
//   MemRead, MemWrite, RegFonte, EscReg, RegOrdem2, PCouSalto,
//   SaltoGeral, Branch, UlaFonte1, CtrlUla          1-bit decoded controls
//   RegOrdem1, RegOrdem3, ExtensorSinal, UlaFonte2  2-bit decoded mux selects
module ctrl_pc_unit #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    opcode,
  input  logic          zero,
  input  logic [AW-1:0] imm,
  input  logic [AW-1:0] sbeq,
  output logic [AW-1:0] pc,
  output logic          branch_taken,
  output logic          MemRead,
  output logic          MemWrite,
  output logic          RegFonte,
  output logic          EscReg,
  output logic          RegOrdem2,
  output logic          PCouSalto,
  output logic          SaltoGeral,
  output logic          Branch,
  output logic          UlaFonte1,
  output logic          CtrlUla,
  output logic [1:0]    RegOrdem1,
  output logic [1:0]    RegOrdem3,
  output logic [1:0]    ExtensorSinal,
  output logic [1:0]    UlaFonte2
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_ADDI = 4'h2,
    OP_LI   = 4'h3,
    OP_LW   = 4'h4,
    OP_SW   = 4'h5,
    OP_BEQ  = 4'h6,
    OP_JR   = 4'h7,
    OP_JMP  = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_e;

  state_e        state, state_next;
  logic          is_halt;
  logic [AW-1:0] offset, base, next_pc;

  // Instruction decode; anything not listed (9-E, unknown) behaves as NOP.
  always_comb begin
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    RegFonte      = 1'b0;
    EscReg        = 1'b0;
    RegOrdem2     = 1'b0;
    PCouSalto     = 1'b0;
    SaltoGeral    = 1'b0;
    Branch        = 1'b0;
    UlaFonte1     = 1'b0;
    CtrlUla       = 1'b0;
    RegOrdem1     = 2'd0;
    RegOrdem3     = 2'd0;
    ExtensorSinal = 2'd0;
    UlaFonte2     = 2'd0;
    is_halt       = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB: begin
        RegOrdem2 = 1'b1;
        UlaFonte2 = 2'd2;
        RegFonte  = 1'b1;
        EscReg    = 1'b1;
        PCouSalto = 1'b1;
        CtrlUla   = (opcode == OP_SUB);
      end
      OP_ADDI: begin
        RegOrdem1     = 2'd1;
        ExtensorSinal = 2'd2;
        RegFonte      = 1'b1;
        EscReg        = 1'b1;
        PCouSalto     = 1'b1;
      end
      OP_LI: begin
        UlaFonte1 = 1'b1;
        UlaFonte2 = 2'd1;
        RegOrdem3 = 2'd2;
        RegFonte  = 1'b1;
        EscReg    = 1'b1;
        PCouSalto = 1'b1;
      end
      OP_LW: begin
        UlaFonte2 = 2'd1;
        MemRead   = 1'b1;
        EscReg    = 1'b1;
        PCouSalto = 1'b1;
      end
      OP_SW: begin
        RegOrdem1     = 2'd1;
        UlaFonte1     = 1'b1;
        UlaFonte2     = 2'd1;
        ExtensorSinal = 2'd2;
        MemWrite      = 1'b1;
        PCouSalto     = 1'b1;
      end
      OP_BEQ: begin
        RegOrdem2  = 1'b1;
        UlaFonte2  = 2'd2;
        CtrlUla    = 1'b1;
        Branch     = 1'b1;
        SaltoGeral = 1'b1;
        PCouSalto  = 1'b1;
      end
      OP_JR: begin
        ExtensorSinal = 2'd1;
        SaltoGeral    = 1'b1;
        PCouSalto     = 1'b1;
      end
      OP_JMP: begin
        ExtensorSinal = 2'd1;
        SaltoGeral    = 1'b1;
      end
      OP_HALT: begin
        is_halt = 1'b1;
      end
      default: begin
        PCouSalto = 1'b1;
      end
    endcase
  end

  assign branch_taken = zero & Branch;

  // Next PC = offset + base, carries dropped.
  always_comb begin
    if (!SaltoGeral)  offset = '0;
    else if (Branch)  offset = zero ? sbeq : '0;
    else              offset = imm;
    base    = PCouSalto ? pc + AW'(1) : '0;
    next_pc = offset + base;
  end

  // Once HALT is executed the PC is frozen until reset, whatever opcode follows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:    if (is_halt) state_next = ST_HALTED;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          pc <= '0;
    else if (state == ST_RUN && !is_halt) pc <= next_pc;
  end

endmodule

// File: tb/tb_ctrl_pc_unit.sv
// Testbench for ctrl_pc_unit: decode table sweep, directed PC sequences and a
// randomized run against a behavioural PC model.
module tb_ctrl_pc_unit;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    opcode;
  logic          zero;
  logic [AW-1:0] imm, sbeq, pc;
  logic          branch_taken;
  logic          MemRead, MemWrite, RegFonte, EscReg, RegOrdem2, PCouSalto;
  logic          SaltoGeral, Branch, UlaFonte1, CtrlUla;
  logic [1:0]    RegOrdem1, RegOrdem3, ExtensorSinal, UlaFonte2;

  // {MemRead MemWrite RegFonte EscReg RegOrdem2 PCouSalto SaltoGeral Branch UlaFonte1 CtrlUla}
  // _{RegOrdem1}_{RegOrdem3}_{ExtensorSinal}_{UlaFonte2}
  typedef logic [17:0] ctrl_t;

  typedef struct {
    logic [3:0] op;
    logic       z;
    ctrl_t      exp_ctrl;
    logic       exp_bt;
  } vec_t;

  ctrl_t dut_ctrl;
  assign dut_ctrl = {MemRead, MemWrite, RegFonte, EscReg, RegOrdem2, PCouSalto,
                     SaltoGeral, Branch, UlaFonte1, CtrlUla,
                     RegOrdem1, RegOrdem3, ExtensorSinal, UlaFonte2};

  ctrl_pc_unit #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .imm(imm), .sbeq(sbeq),
    .pc(pc), .branch_taken(branch_taken),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegFonte(RegFonte), .EscReg(EscReg),
    .RegOrdem2(RegOrdem2), .PCouSalto(PCouSalto), .SaltoGeral(SaltoGeral),
    .Branch(Branch), .UlaFonte1(UlaFonte1), .CtrlUla(CtrlUla),
    .RegOrdem1(RegOrdem1), .RegOrdem3(RegOrdem3), .ExtensorSinal(ExtensorSinal),
    .UlaFonte2(UlaFonte2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [AW-1:0] v);
    opcode = 4'h8;
    imm    = v;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  vec_t  tbl[17];
  ctrl_t ref_ctrl[16];
  logic [AW-1:0] mpc;
  logic          halted;
  logic [3:0]    rop;

  initial begin
    tbl[0]  = '{4'h0, 1'b1, 18'b0011110000_00_00_00_10, 1'b0}; // ADD
    tbl[1]  = '{4'h1, 1'b1, 18'b0011110001_00_00_00_10, 1'b0}; // SUB
    tbl[2]  = '{4'h2, 1'b1, 18'b0011010000_01_00_10_00, 1'b0}; // ADDI
    tbl[3]  = '{4'h3, 1'b1, 18'b0011010010_00_10_00_01, 1'b0}; // LI
    tbl[4]  = '{4'h4, 1'b1, 18'b1001010000_00_00_00_01, 1'b0}; // LW
    tbl[5]  = '{4'h5, 1'b1, 18'b0100010010_01_00_10_01, 1'b0}; // SW
    tbl[6]  = '{4'h6, 1'b1, 18'b0000111101_00_00_00_10, 1'b1}; // BEQ taken
    tbl[7]  = '{4'h7, 1'b1, 18'b0000011000_00_00_01_00, 1'b0}; // JR
    tbl[8]  = '{4'h8, 1'b1, 18'b0000001000_00_00_01_00, 1'b0}; // JMP
    for (int i = 9; i < 15; i++)
      tbl[i] = '{4'(i), 1'b1, 18'b0000010000_00_00_00_00, 1'b0}; // NOP
    tbl[15] = '{4'hF, 1'b1, 18'b0000000000_00_00_00_00, 1'b0}; // HALT
    tbl[16] = '{4'h6, 1'b0, 18'b0000111101_00_00_00_10, 1'b0}; // BEQ not taken

    reset = 1'b0; opcode = 4'h9; zero = 1'b0; imm = '0; sbeq = '0;
    #2;
    check("reset_pc", 32'(pc), 32'h0);

    // Decode sweep while reset is held: outputs must still follow opcode.
    for (int i = 0; i < 17; i++) begin
      opcode = tbl[i].op;
      zero   = tbl[i].z;
      #2;
      check($sformatf("decode_op%0h_z%0d", tbl[i].op, tbl[i].z), 32'(dut_ctrl), 32'(tbl[i].exp_ctrl));
      check($sformatf("bt_op%0h_z%0d", tbl[i].op, tbl[i].z), 32'(branch_taken), 32'(tbl[i].exp_bt));
      if (i < 16) ref_ctrl[tbl[i].op] = tbl[i].exp_ctrl;
    end
    check("pc_held_in_reset", 32'(pc), 32'h0);

    // T1: async reset mid-cycle, then sequential restart
    @(negedge clk);
    reset = 1'b1;
    set_pc(8'h5A);
    check("t1_run_5a", 32'(pc), 32'h5A);
    opcode = 4'h9;
    #3;
    reset = 1'b0;
    #1;
    check("t1_async_clear", 32'(pc), 32'h0);
    tick();
    check("t1_edge_in_reset", 32'(pc), 32'h0);
    reset = 1'b1;
    tick();
    check("t1_release_01", 32'(pc), 32'h1);
    tick();
    check("t1_release_02", 32'(pc), 32'h2);

    // T3: BEQ
    set_pc(8'h10);
    opcode = 4'h6; sbeq = 8'h04; zero = 1'b1;
    #1;
    check("t3_bt_taken", 32'(branch_taken), 32'h1);
    tick();
    check("t3_beq_taken", 32'(pc), 32'h15);
    set_pc(8'h10);
    opcode = 4'h6; zero = 1'b0;
    #1;
    check("t3_bt_not", 32'(branch_taken), 32'h0);
    tick();
    check("t3_beq_not", 32'(pc), 32'h11);

    // T4: JR / JMP
    set_pc(8'h20);
    opcode = 4'h7; imm = 8'h03; tick();
    check("t4_jr", 32'(pc), 32'h24);
    set_pc(8'h20);
    opcode = 4'h8; imm = 8'h03; tick();
    check("t4_jmp", 32'(pc), 32'h03);
    set_pc(8'h20);
    opcode = 4'h7; imm = 8'hFE; tick();
    check("t4_jr_wrap", 32'(pc), 32'h1F);

    // T5: wrap and HALT
    set_pc(8'hFF);
    opcode = 4'h0; tick();
    check("t5_wrap", 32'(pc), 32'h00);
    set_pc(8'h77);
    opcode = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t5_halt_%0d", i), 32'(pc), 32'h77);
    end
    opcode = 4'h9; tick();
    check("t5_halt_sticky", 32'(pc), 32'h77);
    reset = 1'b0;
    #1;
    check("t5_reset_exit", 32'(pc), 32'h00);
    reset = 1'b1;

    // Randomized run against the PC model
    mpc = '0;
    halted = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ((halted && $urandom_range(3) == 0) || $urandom_range(60) == 0) begin
        reset = 1'b0;
        #1;
        check("rnd_reset", 32'(pc), 32'h0);
        mpc = '0;
        halted = 1'b0;
        reset = 1'b1;
      end
      rop    = ($urandom_range(15) == 0) ? 4'hF : 4'($urandom_range(14));
      opcode = rop;
      zero   = 1'($urandom_range(1));
      imm    = 8'($urandom);
      sbeq   = 8'($urandom);
      #1;
      check($sformatf("rnd_decode_op%0h", rop), 32'(dut_ctrl), 32'(ref_ctrl[rop]));
      check("rnd_bt", 32'(branch_taken), 32'(zero && rop == 4'h6));
      tick();
      if (!halted) begin
        case (rop)
          4'h6:    mpc = 8'(mpc + 1 + (zero ? sbeq : 8'h00));
          4'h7:    mpc = 8'(mpc + 1 + imm);
          4'h8:    mpc = imm;
          4'hF:    halted = 1'b1;
          default: mpc = 8'(mpc + 1);
        endcase
      end
      check($sformatf("rnd_pc_op%0h", rop), 32'(pc), 32'(mpc));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
